// File: rtl/norm_arbiter_seq_if.sv
// NormArbiterSeqIf: request/ack lanes for the real and imaginary requesters plus
// the valid/ready result channel of the shared normalization engine.
interface NormArbiterSeqIf #(
   parameter int SIZE  = 10,
   parameter int EXP_W = 5
);
   logic             iReqRe;
   logic [SIZE-1:0]  iMantRe;
   logic [EXP_W-1:0] iExpRe;
   logic             oAckRe;
   logic             iReqIm;
   logic [SIZE-1:0]  iMantIm;
   logic [EXP_W-1:0] iExpIm;
   logic             oAckIm;
   logic             oValid;
   logic             iReady;
   logic [SIZE-1:0]  oMant;
   logic [EXP_W-1:0] oExp;
   logic             oId;
   logic [4:0]       oShifts;

   // Requesters and the downstream consumer sit on the master side
   modport master (
      output iReqRe, iMantRe, iExpRe, iReqIm, iMantIm, iExpIm, iReady,
      input  oAckRe, oAckIm, oValid, oMant, oExp, oId, oShifts
   );

   // The normalization engine sits on the slave side
   modport slave (
      input  iReqRe, iMantRe, iExpRe, iReqIm, iMantIm, iExpIm, iReady,
      output oAckRe, oAckIm, oValid, oMant, oExp, oId, oShifts
   );
endinterface

// File: rtl/norm_arbiter_seq.sv
// norm_arbiter_seq: one time-shared normalizer for both FFT butterfly lanes.
// A round-robin arbiter picks a lane, the operand is left-shifted one bit per
// clock until normalized, zero, or the exponent hits its floor, and the result
// is offered downstream under valid/ready.
module norm_arbiter_seq #(
   parameter int SIZE  = 10,
   parameter int EXP_W = 5
) (
   input logic         Clock,
   input logic         Reset,
   NormArbiterSeqIf.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT            state;
   stateT            stateNext;
   logic [SIZE-1:0]  workMant;
   logic [EXP_W-1:0] workExp;
   logic [4:0]       workShifts;
   logic             lastIm;
   logic             grantRe;
   logic             grantIm;
   logic             terminate;

   // Normalization stops on a zero mantissa, a sign/MSB mismatch, or a zero exponent
   always_comb begin
      terminate = (workMant == '0)
               || (workMant[SIZE-1] != workMant[SIZE-2])
               || (workExp == '0);
   end

   // State register; reset discards whatever operand was in flight
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next state and grant decode; when both lanes ask, the one not served last wins
   always_comb begin
      stateNext = state;
      grantRe   = 1'b0;
      grantIm   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.iReqRe && (!bus.iReqIm || lastIm)) begin
               grantRe = 1'b1;
            end else if (bus.iReqIm) begin
               grantIm = 1'b1;
            end
            if (grantRe || grantIm) begin
               stateNext = NORM;
            end
         end
         NORM: begin
            if (terminate) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            if (bus.iReady) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   assign bus.oAckRe = grantRe;
   assign bus.oAckIm = grantIm;

   // Datapath: capture on grant, shift while not terminated, publish and hold result
   always_ff @(posedge Clock) begin
      if (Reset) begin
         workMant    <= '0;
         workExp     <= '0;
         workShifts  <= '0;
         lastIm      <= 1'b1;
         bus.oValid  <= 1'b0;
         bus.oMant   <= '0;
         bus.oExp    <= '0;
         bus.oId     <= 1'b0;
         bus.oShifts <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grantRe) begin
                  workMant   <= bus.iMantRe;
                  workExp    <= bus.iExpRe;
                  workShifts <= '0;
                  bus.oId    <= 1'b0;
               end else if (grantIm) begin
                  workMant   <= bus.iMantIm;
                  workExp    <= bus.iExpIm;
                  workShifts <= '0;
                  bus.oId    <= 1'b1;
               end
            end
            NORM: begin
               if (terminate) begin
                  bus.oValid  <= 1'b1;
                  bus.oMant   <= workMant;
                  bus.oExp    <= (workMant == '0) ? '0 : workExp;
                  bus.oShifts <= workShifts;
               end else begin
                  workMant   <= {workMant[SIZE-2:0], 1'b0};
                  workExp    <= workExp - EXP_W'(1);
                  workShifts <= workShifts + 5'd1;
               end
            end
            DONE: begin
               if (bus.iReady) begin
                  bus.oValid <= 1'b0;
                  lastIm     <= bus.oId;
               end
            end
            default: begin
               bus.oValid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_norm_arbiter_seq.sv
// tb_norm_arbiter_seq: directed and randomized stimulus for norm_arbiter_seq,
// checked against a transaction-level model of arbitration and normalization.
module tb_norm_arbiter_seq;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   int   cycle = 0;
   int   vectors = 0;
   int   miscompares = 0;

   NormArbiterSeqIf #(.SIZE(10), .EXP_W(5)) bus ();

   norm_arbiter_seq #(.SIZE(10), .EXP_W(5)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   // Free-running clock and cycle counter
   always #5 Clock = ~Clock;

   always @(posedge Clock) cycle <= cycle + 1;

   // Run-away guard
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   // Reference normalization: keep doubling until normalized, zero, or exponent floor
   function automatic logic [19:0] normRef(input logic [9:0] m, input logic [4:0] e);
      logic [9:0] mm = m;
      logic [4:0] ee = e;
      int         n = 0;
      while (mm != 10'd0 && mm[9] == mm[8] && ee != 5'd0) begin
         mm = 10'(mm * 2);
         ee = ee - 5'd1;
         n++;
      end
      if (mm == 10'd0) ee = 5'd0;
      return {mm, ee, 5'(n)};
   endfunction

   // Transaction model state shared with the stimulus tasks
   logic       modelBusy = 1'b0;
   logic       lastImModel = 1'b1;
   logic       resetCheck = 1'b0;
   logic       prevValid = 1'b0;
   logic       expLane = 1'b0;
   logic [9:0] expMant = '0;
   logic [4:0] expExp = '0;
   logic [4:0] expShifts = '0;
   int         ackCycle = 0;
   logic [9:0] heldMant = '0;
   logic [4:0] heldExp = '0;
   logic [4:0] heldShifts = '0;
   logic       heldId = 1'b0;

   // Monitor/scoreboard sampled mid-cycle, away from the rising edge
   always @(negedge Clock) begin
      logic       laneWant;
      logic [19:0] r;
      #2;
      if (Reset) begin
         modelBusy   = 1'b0;
         lastImModel = 1'b1;
         resetCheck  = 1'b1;
         prevValid   = 1'b0;
      end else begin
         if (resetCheck) begin
            checkOutput("rstValid",  int'(bus.oValid),  0);
            checkOutput("rstMant",   int'(bus.oMant),   0);
            checkOutput("rstExp",    int'(bus.oExp),    0);
            checkOutput("rstId",     int'(bus.oId),     0);
            checkOutput("rstShifts", int'(bus.oShifts), 0);
            resetCheck = 1'b0;
         end
         if (bus.oAckRe || bus.oAckIm) begin
            checkOutput("ackExclusive", int'(bus.oAckRe & bus.oAckIm), 0);
            checkOutput("ackWhileBusy", int'(modelBusy), 0);
            laneWant = (bus.iReqRe && bus.iReqIm) ? !lastImModel : bus.iReqIm;
            checkOutput("grantLane", int'(bus.oAckIm), int'(laneWant));
            r = bus.oAckIm ? normRef(bus.iMantIm, bus.iExpIm) : normRef(bus.iMantRe, bus.iExpRe);
            expLane   = bus.oAckIm;
            expMant   = r[19:10];
            expExp    = r[9:5];
            expShifts = r[4:0];
            ackCycle  = cycle;
            modelBusy = 1'b1;
         end else if (!modelBusy && (bus.iReqRe || bus.iReqIm)) begin
            checkOutput("missingAck", 0, 1);
         end
         if (bus.oValid) begin
            if (!modelBusy) begin
               checkOutput("spuriousValid", 1, 0);
            end else if (!prevValid) begin
               checkOutput("resMant",    int'(bus.oMant),    int'(expMant));
               checkOutput("resExp",     int'(bus.oExp),     int'(expExp));
               checkOutput("resShifts",  int'(bus.oShifts),  int'(expShifts));
               checkOutput("resId",      int'(bus.oId),      int'(expLane));
               checkOutput("resLatency", cycle - ackCycle,   2 + int'(expShifts));
            end else begin
               checkOutput("holdMant",   int'(bus.oMant),    int'(heldMant));
               checkOutput("holdExp",    int'(bus.oExp),     int'(heldExp));
               checkOutput("holdShifts", int'(bus.oShifts),  int'(heldShifts));
               checkOutput("holdId",     int'(bus.oId),      int'(heldId));
            end
            heldMant   = bus.oMant;
            heldExp    = bus.oExp;
            heldShifts = bus.oShifts;
            heldId     = bus.oId;
            if (bus.iReady) begin
               modelBusy   = 1'b0;
               lastImModel = expLane;
            end
         end else if (modelBusy && (cycle - ackCycle) > 2 + int'(expShifts)) begin
            checkOutput("validLate", cycle - ackCycle, 2 + int'(expShifts));
            modelBusy = 1'b0;
         end
         prevValid = bus.oValid;
      end
   end

   // Raise a request on one lane, wait for its ack, then drop it
   task automatic applyStimulus(input logic lane, input logic [9:0] mant, input logic [4:0] ex);
      bit got = 1'b0;
      @(negedge Clock);
      if (lane) begin
         bus.iReqIm = 1'b1; bus.iMantIm = mant; bus.iExpIm = ex;
      end else begin
         bus.iReqRe = 1'b1; bus.iMantRe = mant; bus.iExpRe = ex;
      end
      for (int n = 0; n < 60 && !got; n++) begin
         #3;
         got = lane ? bus.oAckIm : bus.oAckRe;
         if (!got) @(negedge Clock);
      end
      if (!got) checkOutput("ackTimeout", 0, 1);
      @(negedge Clock);
      if (lane) bus.iReqIm = 1'b0;
      else      bus.iReqRe = 1'b0;
   endtask

   // Wait for the next result and compare against hand-computed constants
   task automatic expectResult(input string tag, input int mant, input int ex,
                               input int sh, input int id);
      bit got = 1'b0;
      for (int n = 0; n < 60 && !got; n++) begin
         #3;
         got = bus.oValid;
         if (!got) @(negedge Clock);
      end
      if (!got) begin
         checkOutput({tag, "Timeout"}, 0, 1);
      end else begin
         checkOutput({tag, "Mant"},   int'(bus.oMant),   mant);
         checkOutput({tag, "Exp"},    int'(bus.oExp),    ex);
         checkOutput({tag, "Shifts"}, int'(bus.oShifts), sh);
         checkOutput({tag, "Id"},     int'(bus.oId),     id);
      end
      @(negedge Clock);
   endtask

   task automatic waitIdle;
      bit ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge Clock);
         #3;
         ok = !modelBusy && !bus.oValid;
      end
      if (!ok) checkOutput("idleTimeout", 0, 1);
   endtask

   function automatic logic [9:0] randMant();
      case ($urandom_range(0, 3))
         0:       return 10'd0;
         1:       return 10'($urandom_range(1, 15));
         2:       return 10'(10'h3FF - 10'($urandom_range(0, 15)));
         default: return 10'($urandom);
      endcase
   endfunction

   // Random requesters that drop or replace after each ack, plus random backpressure
   task automatic randomPhase(input int nCycles);
      logic ackReLast = 1'b0;
      logic ackImLast = 1'b0;
      for (int c = 0; c < nCycles; c++) begin
         @(negedge Clock);
         if (ackReLast || !bus.iReqRe) begin
            if ($urandom_range(0, 2) == 0) begin
               bus.iReqRe = 1'b1; bus.iMantRe = randMant(); bus.iExpRe = 5'($urandom_range(0, 31));
            end else begin
               bus.iReqRe = 1'b0;
            end
         end
         if (ackImLast || !bus.iReqIm) begin
            if ($urandom_range(0, 2) == 0) begin
               bus.iReqIm = 1'b1; bus.iMantIm = randMant(); bus.iExpIm = 5'($urandom_range(0, 31));
            end else begin
               bus.iReqIm = 1'b0;
            end
         end
         bus.iReady = ($urandom_range(0, 3) != 0);
         #3;
         ackReLast = bus.oAckRe;
         ackImLast = bus.oAckIm;
      end
      @(negedge Clock);
      if (!ackReLast && bus.iReqRe) begin
         bus.iReady = 1'b1;
      end
      bus.iReady = 1'b1;
   endtask

   // Main sequence
   initial begin
      bus.iReqRe = 1'b0; bus.iMantRe = '0; bus.iExpRe = '0;
      bus.iReqIm = 1'b0; bus.iMantIm = '0; bus.iExpIm = '0;
      bus.iReady = 1'b1;
      Reset = 1'b1;
      repeat (3) @(negedge Clock);
      Reset = 1'b0;

      applyStimulus(1'b0, 10'h035, 5'd10);
      expectResult("tpShift3", 'h1A8, 7, 3, 0);
      waitIdle();
      applyStimulus(1'b1, 10'h3F2, 5'd12);
      expectResult("tpShift5", 'h240, 7, 5, 1);
      waitIdle();
      applyStimulus(1'b0, 10'h001, 5'd2);
      expectResult("tpFloor", 'h004, 0, 2, 0);
      waitIdle();
      applyStimulus(1'b0, 10'h000, 5'd9);
      expectResult("tpZero", 0, 0, 0, 0);
      waitIdle();

      // Both lanes requesting continuously from reset
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      bus.iReqRe = 1'b1; bus.iMantRe = 10'h035; bus.iExpRe = 5'd10;
      bus.iReqIm = 1'b1; bus.iMantIm = 10'h3F2; bus.iExpIm = 5'd12;
      #3;
      checkOutput("bothFirstRe", int'(bus.oAckRe), 1);
      repeat (40) @(negedge Clock);
      bus.iReqRe = 1'b0;
      bus.iReqIm = 1'b0;
      waitIdle();

      // Backpressure: hold the result while the other lane waits
      bus.iReady = 1'b0;
      applyStimulus(1'b0, 10'h035, 5'd10);
      for (int n = 0; n < 30 && !bus.oValid; n++) @(negedge Clock);
      @(negedge Clock);
      bus.iReqIm = 1'b1; bus.iMantIm = 10'h07F; bus.iExpIm = 5'd20;
      repeat (5) @(negedge Clock);
      #3;
      checkOutput("bpValidHeld", int'(bus.oValid), 1);
      checkOutput("bpNoAck", int'(bus.oAckIm), 0);
      @(negedge Clock);
      bus.iReady = 1'b1;
      applyStimulus(1'b1, 10'h07F, 5'd20);
      waitIdle();

      // Reset in the middle of a five-shift normalization
      applyStimulus(1'b1, 10'h3F2, 5'd12);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      bus.iReqRe = 1'b1; bus.iMantRe = 10'h035; bus.iExpRe = 5'd10;
      bus.iReqIm = 1'b1; bus.iMantIm = 10'h3F2; bus.iExpIm = 5'd12;
      #3;
      checkOutput("rstGrantRe", int'(bus.oAckRe), 1);
      checkOutput("rstNoAckIm", int'(bus.oAckIm), 0);
      @(negedge Clock);
      bus.iReqRe = 1'b0;
      bus.iReqIm = 1'b0;
      waitIdle();

      randomPhase(800);
      bus.iReqRe = 1'b0;
      bus.iReqIm = 1'b0;
      waitIdle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
